// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and load-buffer state encoding for the writeback arbiter
//
// Contents:
//   WB_WIDTH  default write data width
//   WB_AW     default register address width
//   wb_cnt_e  load buffer occupancy: EMPTY(0), ONE(1), FULL(2)
package wb_pkg;

  localparam int WB_WIDTH = 32;
  localparam int WB_AW    = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_cnt_e;

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry in-order buffer with simultaneous push and pop
//
// Ports:
//   clk        in   clock, rising edge
//   i_rst_n    in   synchronous active-low reset (clears occupancy only)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   W-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   head       out  current head entry
//   count      out  occupancy, encoded as wb_cnt_e
import wb_pkg::*;

module wb_fifo2 #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  wb_cnt_e      state;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         push_ok;
  logic         pop_ok;
  logic         wr_slot1;

  assign push_ok = push && (state != FULL);
  assign pop_ok  = pop && (state != EMPTY);

  // mem0 is always the head; on a pop the tail shifts down, so the new
  // entry lands in the slot that is free after the shift.
  assign wr_slot1 = pop_ok ? (state == FULL) : (state == ONE);

  assign head  = mem0;
  assign count = state;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state <= EMPTY;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   state <= (state == EMPTY) ? ONE : FULL;
        2'b01:   state <= (state == FULL) ? ONE : EMPTY;
        default: state <= state;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (pop_ok) mem0 <= mem1;
    if (push_ok) begin
      if (wr_slot1) mem1 <= push_data;
      else          mem0 <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter between ALU results and buffered loads
//
// Ports:
//   clk, i_rst_n                         clock, synchronous active-low reset
//   i_alu_valid/addr/data, o_alu_ready   ALU writeback request
//   i_mem_valid/addr/data, o_mem_ready   load writeback request
//   o_wr_en/addr/data                    registered register-file write port
//   o_mem_count                          load buffer occupancy (0..2)
//
// Build option WB_X0_DISCARD_EN: a winner targeting address 0 is consumed
// but produces no write.
import wb_pkg::*;

module wb_arbiter #(
  parameter int WIDTH = WB_WIDTH,
  parameter int AW    = WB_AW
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_alu_valid,
  input  logic [AW-1:0]    i_alu_addr,
  input  logic [WIDTH-1:0] i_alu_data,
  output logic             o_alu_ready,
  input  logic             i_mem_valid,
  input  logic [AW-1:0]    i_mem_addr,
  input  logic [WIDTH-1:0] i_mem_data,
  output logic             o_mem_ready,
  output logic             o_wr_en,
  output logic [AW-1:0]    o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic [1:0]       o_mem_count
);

  localparam int EW = AW + WIDTH;

  logic [EW-1:0]    head;
  logic [1:0]       count;
  logic             ready;
  logic             sel_head;
  logic             sel_alu;
  logic             sel_byp;
  logic             push;
  logic             win_valid;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic             discard;

  // Readiness depends only on registered occupancy, never on valids.
  assign ready       = (count != FULL);
  assign o_alu_ready = ready;
  assign o_mem_ready = ready;
  assign o_mem_count = count;

  // A full buffer must drain first so loads can never be starved forever;
  // otherwise the ALU wins, then older buffered loads, then a bypassing load.
  always_comb begin
    sel_head = 1'b0;
    sel_alu  = 1'b0;
    sel_byp  = 1'b0;
    if (count == FULL)       sel_head = 1'b1;
    else if (i_alu_valid)    sel_alu  = 1'b1;
    else if (count != EMPTY) sel_head = 1'b1;
    else if (i_mem_valid)    sel_byp  = 1'b1;
  end

  assign push = i_mem_valid && ready && !sel_byp;

  always_comb begin
    win_valid = sel_head || sel_alu || sel_byp;
    win_addr  = '0;
    win_data  = '0;
    if (sel_head) begin
      win_addr = head[EW-1 -: AW];
      win_data = head[WIDTH-1:0];
    end else if (sel_alu) begin
      win_addr = i_alu_addr;
      win_data = i_alu_data;
    end else if (sel_byp) begin
      win_addr = i_mem_addr;
      win_data = i_mem_data;
    end
  end

`ifdef WB_X0_DISCARD_EN
  assign discard = win_valid && (win_addr == '0);
`else
  assign discard = 1'b0;
`endif

  wb_fifo2 #(.W(EW)) u_fifo (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .push_data ({i_mem_addr, i_mem_data}),
    .pop       (sel_head),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= win_valid && !discard;
      if (win_valid) begin
        o_wr_addr <= win_addr;
        o_wr_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_alu_valid;
  logic [4:0]  i_alu_addr;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_mem_valid;
  logic [4:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_mem_ready;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [1:0]  o_mem_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef WB_X0_DISCARD_EN
  localparam bit X0_WRITES = 1'b0;
`else
  localparam bit X0_WRITES = 1'b1;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH(32), .AW(5)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_alu_valid (i_alu_valid),
    .i_alu_addr  (i_alu_addr),
    .i_alu_data  (i_alu_data),
    .o_alu_ready (o_alu_ready),
    .i_mem_valid (i_mem_valid),
    .i_mem_addr  (i_mem_addr),
    .i_mem_data  (i_mem_data),
    .o_mem_ready (o_mem_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_mem_count (o_mem_count)
  );

  typedef struct {
    bit        rst_n;
    bit        av;
    bit [4:0]  aa;
    bit [31:0] ad;
    bit        mv;
    bit [4:0]  ma;
    bit [31:0] md;
    bit        e_en;
    bit [4:0]  e_addr;
    bit [31:0] e_data;
    bit [1:0]  e_cnt;
    bit        e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst_n, bit av, bit [4:0] aa, bit [31:0] ad,
                              bit mv, bit [4:0] ma, bit [31:0] md,
                              bit e_en, bit [4:0] e_addr, bit [31:0] e_data,
                              bit [1:0] e_cnt, bit e_rdy);
    vec_t v;
    v.rst_n = rst_n; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md;
    v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(bit rst_n, bit av, bit [4:0] aa, bit [31:0] ad,
                       bit mv, bit [4:0] ma, bit [31:0] md);
    i_rst_n = rst_n; i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
    i_mem_valid = mv; i_mem_addr = ma; i_mem_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst alu(v,a,d) mem(v,a,d) -> en addr data count ready
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,  0,            0, 0,  32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 0,  32'h0,        0, 1));
    vecs.push_back(mk(1, 1, 3, 32'hAAAA0001, 0, 0,  0,            1, 3,  32'hAAAA0001, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 3,  32'hAAAA0001, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            1, 7,  32'h12345678, 1, 7,  32'h12345678, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 7,  32'h12345678, 0, 1));
    // contention: ALU wins twice, buffer fills, ALU stalls one cycle
    vecs.push_back(mk(1, 1, 1, 32'h11,       1, 9,  32'h91,       1, 1,  32'h11,       1, 1));
    vecs.push_back(mk(1, 1, 2, 32'h12,       1, 10, 32'h92,       1, 2,  32'h12,       2, 0));
    vecs.push_back(mk(1, 1, 4, 32'h13,       1, 11, 32'h93,       1, 9,  32'h91,       1, 1));
    vecs.push_back(mk(1, 1, 4, 32'h13,       1, 11, 32'h93,       1, 4,  32'h13,       2, 0));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 10, 32'h92,       1, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 11, 32'h93,       0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 11, 32'h93,       0, 1));
    // fill, then reset discards the buffered loads
    vecs.push_back(mk(1, 1, 5, 32'h21,       1, 12, 32'h94,       1, 5,  32'h21,       1, 1));
    vecs.push_back(mk(1, 1, 6, 32'h22,       1, 13, 32'h95,       1, 6,  32'h22,       2, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,  0,            0, 0,  32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 0,  32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 0,  32'h0,        0, 1));
    // address 0 write
    vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 0, 0,  0,            X0_WRITES, 0, 32'hFFFFFFFF, 0, 1));
    // push and pop together at ONE keeps order
    vecs.push_back(mk(1, 1, 1, 32'h31,       1, 14, 32'h96,       1, 1,  32'h31,       1, 1));
    vecs.push_back(mk(1, 0, 0, 0,            1, 15, 32'h97,       1, 14, 32'h96,       1, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 15, 32'h97,       0, 1));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,            0, 15, 32'h97,       0, 1));

    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].av, vecs[i].aa, vecs[i].ad,
            vecs[i].mv, vecs[i].ma, vecs[i].md);
      step();
      check($sformatf("v%0d wr_en", i),     {31'b0, o_wr_en},     {31'b0, vecs[i].e_en});
      check($sformatf("v%0d wr_addr", i),   {27'b0, o_wr_addr},   {27'b0, vecs[i].e_addr});
      check($sformatf("v%0d wr_data", i),   o_wr_data,            vecs[i].e_data);
      check($sformatf("v%0d mem_count", i), {30'b0, o_mem_count}, {30'b0, vecs[i].e_cnt});
      check($sformatf("v%0d alu_ready", i), {31'b0, o_alu_ready}, {31'b0, vecs[i].e_rdy});
      check($sformatf("v%0d mem_ready", i), {31'b0, o_mem_ready}, {31'b0, vecs[i].e_rdy});
    end

    // back-to-back loads on an empty buffer all bypass, in order
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 1, 5'(20 + k), 32'hB000 + k);
      step();
      check($sformatf("byp%0d wr_en", k),   {31'b0, o_wr_en},     32'd1);
      check($sformatf("byp%0d wr_addr", k), {27'b0, o_wr_addr},   32'(20 + k));
      check($sformatf("byp%0d wr_data", k), o_wr_data,            32'hB000 + k);
      check($sformatf("byp%0d count", k),   {30'b0, o_mem_count}, 32'd0);
    end

    // full buffer blocks a lone ALU request for exactly one cycle
    drive(1, 1, 2, 32'hC1, 1, 24, 32'hD1);
    step();
    drive(1, 1, 3, 32'hC2, 1, 25, 32'hD2);
    step();
    check("full count", {30'b0, o_mem_count}, 32'd2);
    drive(1, 1, 8, 32'hC3, 0, 0, 0);
    step();
    check("stall head addr", {27'b0, o_wr_addr}, 32'd24);
    check("stall count",     {30'b0, o_mem_count}, 32'd1);
    step();
    check("after stall addr", {27'b0, o_wr_addr}, 32'd8);
    check("after stall data", o_wr_data, 32'hC3);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    check("drain addr", {27'b0, o_wr_addr}, 32'd25);
    check("drain data", o_wr_data, 32'hD2);
    check("drain count", {30'b0, o_mem_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: write data width in bits.
REQ-002 Parameter AW, default 5: register address width in bits.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-low, i_rst_n.
REQ-004 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  Synchronous active-low reset.
REQ-006 i_alu_valid  input  1  ALU writeback request.
REQ-007 i_alu_addr  input  AW  ALU destination register.
REQ-008 i_alu_data  input  WIDTH  ALU result.
REQ-009 o_alu_ready  output  1  ALU request accepted this cycle when high with i_alu_valid.
REQ-010 i_mem_valid  input  1  Load writeback request.
REQ-011 i_mem_addr  input  AW  Load destination register.
REQ-012 i_mem_data  input  WIDTH  Load result.
REQ-013 o_mem_ready  output  1  Load request accepted this cycle when high with i_mem_valid.
REQ-014 o_wr_en  output  1  Register file write enable, registered.
REQ-015 o_wr_addr  output  AW  Register file write address, registered.
REQ-016 o_wr_data  output  WIDTH  Register file write data, registered.
REQ-017 o_mem_count  output  2  Current load buffer occupancy (0..2).

Function
REQ-018 Load path SHALL include a 2-entry in-order buffer; its occupancy is the state: EMPTY(0), ONE(1), FULL(2).
REQ-019 o_alu_ready and o_mem_ready SHALL both equal (count != FULL), derived from registered state only.
REQ-020 Each cycle exactly one winner SHALL be chosen, in priority order: buffer head if FULL; else ALU if i_alu_valid; else buffer head if count>0; else incoming load if i_mem_valid (bypass); else none.
REQ-021 Winner's addr/data SHALL appear on o_wr_* with o_wr_en=1 in the cycle after acceptance (latency 1); with no winner, o_wr_en SHALL be 0 and o_wr_addr/o_wr_data SHALL hold.
REQ-022 An accepted load that is not the bypass winner SHALL be pushed at the buffer tail in the same cycle.
REQ-023 Buffer transitions: push only -> count+1; pop only -> count-1; push+pop -> count unchanged, order kept; FULL accepts no push.
REQ-024 Loads SHALL be written in acceptance order; ALU and load writes SHALL never merge or be lost.
REQ-025 When FULL, the ALU SHALL stall for exactly one cycle per FULL cycle (head drains, next cycle count=ONE).
REQ-026 Simultaneous ALU and load, count<FULL: ALU writes next cycle, load pushed.

Reset
REQ-027 With i_rst_n=0 at a clk edge: count=EMPTY, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_mem_count=0.
REQ-028 Reset mid-operation SHALL discard buffered loads and any pending write; no write issued in the cycle after reset.
REQ-029 Buffer storage contents need not be reset.

Configuration
REQ-030 Macro WB_X0_DISCARD_EN: when defined, any winner with address 0 SHALL be consumed normally (handshake and buffer pop as usual) but produce o_wr_en=0 next cycle.
REQ-031 Without WB_X0_DISCARD_EN, address 0 SHALL be written like any other address.

Structure
REQ-032 Package wb_pkg SHALL hold default WIDTH/AW constants and the buffer-state encoding (EMPTY/ONE/FULL).
REQ-033 Buffer SHALL be sub-module wb_fifo2 (2-entry, push/pop/count, simultaneous push+pop).

Verification
REQ-034 Reset, idle: after i_rst_n=0 then 1, no valids -> o_wr_en=0, o_mem_count=0, both readies=1.
REQ-035 Single ALU: alu addr=3 data=0xAAAA0001 cycle N -> o_wr_en=1, addr=3, data=0xAAAA0001 cycle N+1 only.
REQ-036 Load bypass: mem addr=7 data=0x12345678, no ALU, count=0 -> written cycle N+1, count stays 0.
REQ-037 Contention fill: ALU and mem valid 3 consecutive cycles -> ALU writes 2 cycles, count reaches 2, readies drop, load head (first load) written next, loads emerge in order 1,2,3.
REQ-038 Reset mid-operation: count=2, assert i_rst_n=0 one cycle -> count=0, o_wr_en=0, buffered loads never written.
REQ-039 With WB_X0_DISCARD_EN: ALU addr=0 data=0xFFFFFFFF -> o_alu_ready=1, o_wr_en stays 0; without macro -> o_wr_en=1, addr=0.
